gate_test_sequencer: RTL and testbench

- Sequencer that exhaustively exercises a combinational gate under test (DUT): drives every input vector in ascending order, waits a fixed settle time, samples the DUT output and compares it against a parameterised truth table.
- Sits beside each lab gate (and_gate and its siblings) as a synthesizable self-checker, so gate correctness can be checked on hardware or by a thin bench.
- Reports mismatch count, the first failing vector and a pass flag.

---
 rtl/gate_test_pkg.sv | 23 ++
 rtl/gate_test_sequencer_settle_timer.sv | 29 ++
 rtl/gate_test_sequencer.sv | 135 +++++++++++++
 tb/tb_gate_test_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate self-check sequencer and the lab gate benches.
package gate_test_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Truth tables of the two-input lab gates; bit i is the output for input vector i
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

  // Width of a truth table (number of input vectors) for a gate with n_in inputs
  function automatic int unsigned vec_count(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/gate_test_sequencer_settle_timer.sv
// Loadable down-counter that measures how long the DUT inputs have been held.
module settle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and stop at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive self-checker for a combinational gate: walks every input vector,
// lets it settle, samples the gate output and compares it with a truth table.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned                  N_IN   = 2,
  parameter int unsigned                  SETTLE = 2,
  parameter logic [vec_count(N_IN)-1:0]   EXPECT = TT_AND2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            dut_y_i,
  output logic [N_IN-1:0] dut_in_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_count_o,
  output logic            fail_valid_o,
  output logic [N_IN-1:0] first_fail_o
);

  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE     = (N_IN + 1)'(1);

  state_e          state_q;
  logic [N_IN-1:0] dut_in_q;
  logic [N_IN:0]   err_count_q;
  logic [N_IN-1:0] first_fail_q;
  logic            fail_valid_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;

  logic            mismatch_s;
  logic [N_IN:0]   err_next_s;
  logic            timer_load_s;
  logic            timer_zero_s;

  // The timer is reloaded in every state except SETTLE, so it is always
  // primed with SETTLE-1 on the edge that enters SETTLE.
  assign timer_load_s = (state_q != ST_SETTLE);
  assign mismatch_s   = dut_y_i ^ EXPECT[dut_in_q];
  assign err_next_s   = mismatch_s ? (err_count_q + ERR_ONE) : err_count_q;

  settle_timer #(
    .W(8)
  ) u_settle_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (timer_load_s),
    .value_i(SETTLE_LOAD),
    .zero_o (timer_zero_s)
  );

  // Sequencer FSM with its registered result and status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      dut_in_q     <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q      <= ST_SETTLE;
            dut_in_q     <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort_i) begin
            state_q  <= ST_IDLE;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
          end else if (timer_zero_s) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort_i) begin
            state_q  <= ST_IDLE;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
          end else begin
            err_count_q <= err_next_s;
            if (mismatch_s && !fail_valid_q) begin
              first_fail_q <= dut_in_q;
              fail_valid_q <= 1'b1;
            end
            // Terminate on the all-ones vector so dut_in never wraps
            if (dut_in_q == LAST_VEC) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_next_s == '0);
            end else begin
              state_q  <= ST_SETTLE;
              dut_in_q <= dut_in_q + VEC_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_in_o     = dut_in_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_count_q;
  assign fail_valid_o = fail_valid_q;
  assign first_fail_o = first_fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: AND/OR gates at default parameters
// plus a 3-input AND instance with a one-cycle settle time.
module tb_gate_test_sequencer;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic or_mode;
  logic start3;
  logic abort3;

  logic [1:0] dut_in;
  logic       dut_y;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail;

  logic [2:0] dut3_in;
  logic       dut3_y;
  logic       busy3, done3, pass3, fail_valid3;
  logic [3:0] err_count3;
  logic [2:0] first_fail3;

  int total = 0;
  int bad   = 0;

  // Gate models driven by the sequencers
  assign dut_y  = or_mode ? (|dut_in) : (&dut_in);
  assign dut3_y = &dut3_in;

  gate_test_sequencer u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .dut_y_i     (dut_y),
    .dut_in_o    (dut_in),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_count_o (err_count),
    .fail_valid_o(fail_valid),
    .first_fail_o(first_fail)
  );

  gate_test_sequencer #(
    .N_IN  (3),
    .SETTLE(1),
    .EXPECT(8'h80)
  ) u_dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start3),
    .abort_i     (abort3),
    .dut_y_i     (dut3_y),
    .dut_in_o    (dut3_in),
    .busy_o      (busy3),
    .done_o      (done3),
    .pass_o      (pass3),
    .err_count_o (err_count3),
    .fail_valid_o(fail_valid3),
    .first_fail_o(first_fail3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start for exactly one rising edge (edge 0 of a run)
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; or_mode = 1'b0;
    start3 = 1'b0; abort3 = 1'b0;
    step(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dut_in", 32'(dut_in), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // AND gate: vectors 0..3 each held 3 cycles, done on edge 12
    pulse_start();
    chk("and_v0_e0", 32'(dut_in), 32'd0);
    chk("and_busy", 32'(busy), 32'd1);
    step(2);
    chk("and_v0_e2", 32'(dut_in), 32'd0);
    step(1);
    chk("and_v1_e3", 32'(dut_in), 32'd1);
    step(3);
    chk("and_v2_e6", 32'(dut_in), 32'd2);
    step(3);
    chk("and_v3_e9", 32'(dut_in), 32'd3);
    step(2);
    chk("and_done_e11", 32'(done), 32'd0);
    step(1);
    chk("and_done_e12", 32'(done), 32'd1);
    chk("and_busy_e12", 32'(busy), 32'd0);
    chk("and_pass", 32'(pass), 32'd1);
    chk("and_err", 32'(err_count), 32'd0);
    chk("and_fv", 32'(fail_valid), 32'd0);
    chk("and_dut_in_hold", 32'(dut_in), 32'd3);

    // Abort while DONE has no effect
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_done_done", 32'(done), 32'd1);
    chk("abort_done_pass", 32'(pass), 32'd1);

    // OR gate with a re-pulsed start at edge 5: mismatches at 01 and 10
    or_mode = 1'b1;
    pulse_start();
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("or_restart_ignored_v", 32'(dut_in), 32'd1);
    step(6);
    chk("or_done_e11", 32'(done), 32'd0);
    step(1);
    chk("or_done_e12", 32'(done), 32'd1);
    chk("or_err", 32'(err_count), 32'd2);
    chk("or_first_fail", 32'(first_fail), 32'd1);
    chk("or_fv", 32'(fail_valid), 32'd1);
    chk("or_pass", 32'(pass), 32'd0);

    // Restart from DONE clears results on the start edge
    pulse_start();
    chk("rerun_err_clr", 32'(err_count), 32'd0);
    chk("rerun_fv_clr", 32'(fail_valid), 32'd0);
    chk("rerun_ff_clr", 32'(first_fail), 32'd0);
    chk("rerun_done_clr", 32'(done), 32'd0);
    chk("rerun_dut_in", 32'(dut_in), 32'd0);
    step(12);
    chk("rerun_done", 32'(done), 32'd1);
    chk("rerun_err", 32'(err_count), 32'd2);
    chk("rerun_ff", 32'(first_fail), 32'd1);

    // Abort while vector 10 settles (sampled on edge 8)
    pulse_start();
    step(7);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_err", 32'(err_count), 32'd1);
    chk("abort_ff", 32'(first_fail), 32'd1);
    chk("abort_fv", 32'(fail_valid), 32'd1);
    chk("abort_dut_in", 32'(dut_in), 32'd0);
    step(3);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd1);
    chk("start_abort_err", 32'(err_count), 32'd0);

    // Asynchronous reset mid-SETTLE, between clock edges
    step(3);
    chk("pre_rst_dut_in", 32'(dut_in), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dut_in", 32'(dut_in), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    chk("arst_fv", 32'(fail_valid), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(14);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    // 3-input AND, SETTLE=1: 8 vectors of 2 cycles, done on edge 16
    start3 = 1'b1;
    step(1);
    start3 = 1'b0;
    step(2);
    chk("and3_v1_e2", 32'(dut3_in), 32'd1);
    step(13);
    chk("and3_done_e15", 32'(done3), 32'd0);
    step(1);
    chk("and3_done_e16", 32'(done3), 32'd1);
    chk("and3_pass", 32'(pass3), 32'd1);
    chk("and3_err", 32'(err_count3), 32'd0);
    chk("and3_dut_in", 32'(dut3_in), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
